// File: rtl/aes_wb_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : aes_wb_ctrl
// Description : Wishbone register block that loads key/plaintext, launches
//               the AES core, captures the result and raises status/IRQ.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_wb_ctrl #(
    parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter int          TO_W           = 11
) (
    input  logic         wb_clk_i,
    input  logic         wb_rstn_i,
    input  logic         wbs_cyc_i,
    input  logic         wbs_stb_i,
    input  logic         wbs_we_i,
    input  logic [3:0]   wbs_sel_i,
    input  logic [31:0]  wbs_adr_i,
    input  logic [31:0]  wbs_dat_i,
    output logic         wbs_ack_o,
    output logic [31:0]  wbs_dat_o,
    output logic [127:0] aes_key_o,
    output logic [127:0] aes_din_o,
    output logic         aes_start_o,
    input  logic         aes_done_i,
    input  logic [127:0] aes_dout_i,
    output logic         irq_o
);
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_START = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;
    localparam logic [TO_W-1:0] c_TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]      r_state;
    logic [TO_W-1:0] r_cnt;
    logic            r_ack;
    logic [31:0]     r_dat;
    logic            r_irq_en;
    logic            r_done;
    logic            r_to;
    logic            r_err;
    logic [127:0]    r_key;
    logic [127:0]    r_din;
    logic [127:0]    r_dout;

    logic [5:0]      w_word;
    logic            w_sel;
    logic            w_wr;
    logic            w_busy;
    logic            w_ctrl_wr;
    logic            w_start_req;
    logic            w_clr;
    logic            w_key_wr;
    logic            w_din_wr;
    logic            w_drop;
    logic            w_go;
    logic            w_done_hit;
    logic            w_to_hit;
    logic [31:0]     w_rdata;
    logic            w_unused;

    // A pending ack blocks selection, so a held request is served every other cycle.
    assign w_word      = wbs_adr_i[7:2];
    assign w_sel       = wbs_cyc_i & wbs_stb_i & ~r_ack & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign w_wr        = w_sel & wbs_we_i;
    assign w_busy      = (r_state != c_IDLE);
    assign w_ctrl_wr   = w_wr & (w_word == 6'd0) & wbs_sel_i[0];
    assign w_start_req = w_ctrl_wr & wbs_dat_i[0];
    assign w_clr       = w_ctrl_wr & wbs_dat_i[2];
    assign w_key_wr    = w_wr & (w_word[5:2] == 4'd1);
    assign w_din_wr    = w_wr & (w_word[5:2] == 4'd2);
    assign w_drop      = w_busy & (w_key_wr | w_din_wr | w_start_req);
    assign w_go        = w_start_req & ~w_busy;
    assign w_done_hit  = (r_state == c_WAIT) & aes_done_i;
    assign w_to_hit    = (r_state == c_WAIT) & ~aes_done_i & (r_cnt == c_TO_LAST);
    assign w_unused    = ^wbs_adr_i[1:0];

    always_comb begin
        w_rdata = 32'd0;
        case (w_word)
            6'd0:                   w_rdata = {30'd0, r_irq_en, 1'b0};
            6'd1:                   w_rdata = {28'd0, r_err, r_to, r_done, w_busy};
            6'd4, 6'd5, 6'd6, 6'd7:     w_rdata = r_key[{w_word[1:0], 5'd0} +: 32];
            6'd8, 6'd9, 6'd10, 6'd11:   w_rdata = r_din[{w_word[1:0], 5'd0} +: 32];
            6'd12, 6'd13, 6'd14, 6'd15: w_rdata = r_dout[{w_word[1:0], 5'd0} +: 32];
            default:                w_rdata = 32'd0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rstn_i) begin
            r_state  <= c_IDLE;
            r_cnt    <= '0;
            r_ack    <= 1'b0;
            r_dat    <= 32'd0;
            r_irq_en <= 1'b0;
            r_done   <= 1'b0;
            r_to     <= 1'b0;
            r_err    <= 1'b0;
            r_key    <= 128'd0;
            r_din    <= 128'd0;
            r_dout   <= 128'd0;
        end else begin
            r_ack <= w_sel;
            r_dat <= (w_sel & ~wbs_we_i) ? w_rdata : 32'd0;

            if (w_ctrl_wr) begin
                r_irq_en <= wbs_dat_i[1];
            end

            // Key/plaintext are frozen while the core is running.
            for (int b = 0; b < 4; b++) begin
                if (wbs_sel_i[b] && !w_busy) begin
                    if (w_key_wr) begin
                        r_key[{w_word[1:0], 5'd0} + 7'(b * 8) +: 8] <= wbs_dat_i[5'(b * 8) +: 8];
                    end
                    if (w_din_wr) begin
                        r_din[{w_word[1:0], 5'd0} + 7'(b * 8) +: 8] <= wbs_dat_i[5'(b * 8) +: 8];
                    end
                end
            end

            // Sticky sets win over a simultaneous clear.
            r_done <= w_done_hit | (r_done & ~w_clr);
            r_to   <= w_to_hit   | (r_to   & ~w_clr);
            r_err  <= w_drop     | (r_err  & ~w_clr);

            case (r_state)
                c_IDLE: begin
                    if (w_go) begin
                        r_state <= c_START;
                    end
                end
                c_START: begin
                    r_cnt   <= '0;
                    r_state <= c_WAIT;
                end
                c_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (aes_done_i) begin
                        r_dout  <= aes_dout_i;
                        r_state <= c_DONE;
                    end else if (r_cnt == c_TO_LAST) begin
                        r_state <= c_DONE;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign wbs_ack_o   = r_ack;
    assign wbs_dat_o   = r_dat;
    assign aes_key_o   = r_key;
    assign aes_din_o   = r_din;
    assign aes_start_o = (r_state == c_START);
    assign irq_o       = r_done & r_irq_en;

endmodule
`default_nettype wire

// File: tb/tb_aes_wb_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_wb_ctrl
// Description : Directed self-checking bench for the AES Wishbone controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_wb_ctrl;
    localparam logic [31:0] A_CTRL = 32'h3000_0000;
    localparam logic [31:0] A_STAT = 32'h3000_0004;
    localparam logic [31:0] A_KEY  = 32'h3000_0010;
    localparam logic [31:0] A_DIN  = 32'h3000_0020;
    localparam logic [31:0] A_DOUT = 32'h3000_0030;

    logic         clk;
    logic         rstn;
    logic         cyc;
    logic         stb;
    logic         we;
    logic [3:0]   sel;
    logic [31:0]  adr;
    logic [31:0]  dat_w;
    logic         ack;
    logic [31:0]  dat_r;
    logic [127:0] key_o;
    logic [127:0] din_o;
    logic         start_o;
    logic         done_i;
    logic [127:0] dout_i;
    logic         irq;

    int errors = 0;
    int checks = 0;
    int start_cnt = 0;

    logic [127:0] key_v;
    logic [127:0] din_v;
    logic [127:0] ct_v;

    aes_wb_ctrl #(
        .BASE_ADDR      (32'h3000_0000),
        .TIMEOUT_CYCLES (16),
        .TO_W           (5)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rstn_i   (rstn),
        .wbs_cyc_i   (cyc),
        .wbs_stb_i   (stb),
        .wbs_we_i    (we),
        .wbs_sel_i   (sel),
        .wbs_adr_i   (adr),
        .wbs_dat_i   (dat_w),
        .wbs_ack_o   (ack),
        .wbs_dat_o   (dat_r),
        .aes_key_o   (key_o),
        .aes_din_o   (din_o),
        .aes_start_o (start_o),
        .aes_done_i  (done_i),
        .aes_dout_i  (dout_i),
        .irq_o       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        forever begin
            @(negedge clk);
            if (start_o === 1'b1) start_cnt++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    // Bus tasks are entered on a falling edge and return on one.
    task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        if (ack) @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; dat_w = d; sel = s;
        @(negedge clk);
        checks++;
        if (ack !== 1'b1) begin
            errors++;
            $display("FAIL write_ack adr=%h: got ack=%b, expected 1", a, ack);
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
        if (ack) @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; sel = 4'hf;
        @(negedge clk);
        checks++;
        if (ack !== 1'b1) begin
            errors++;
            $display("FAIL read_ack adr=%h: got ack=%b, expected 1", a, ack);
        end
        d = dat_r;
        cyc = 1'b0; stb = 1'b0;
    endtask

    task automatic wait_idle(input int max_polls);
        logic [31:0] s;
        int n;
        n = 0;
        do begin
            wb_read(A_STAT, s);
            n++;
        end while (s[0] && n < max_polls);
        checks++;
        if (s[0] !== 1'b0) begin
            errors++;
            $display("FAIL wait_idle: got busy=%b after %0d polls, expected 0", s[0], n);
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rstn = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
        adr = 32'h0; dat_w = 32'h0; done_i = 1'b0; dout_i = 128'h0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        checks++;
        if ({ack, dat_r, start_o, irq} !== 34'h0) begin
            errors++;
            $display("FAIL reset_outputs: got ack=%b dat=%h start=%b irq=%b, expected all 0", ack, dat_r, start_o, irq);
        end
        checks++;
        if (key_o !== 128'h0 || din_o !== 128'h0) begin
            errors++;
            $display("FAIL reset_key_din: got key=%h din=%h, expected 0", key_o, din_o);
        end
        wb_read(A_STAT, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_status: got %h, expected 0", d); end
        wb_read(A_CTRL, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_ctrl: got %h, expected 0", d); end
    endtask

    task automatic test_encrypt();
        logic [31:0] d;
        int cnt0;
        for (int i = 0; i < 4; i++) begin
            wb_write(A_KEY + 32'(4 * i), key_v[i*32 +: 32], 4'hf);
            wb_write(A_DIN + 32'(4 * i), din_v[i*32 +: 32], 4'hf);
        end
        checks++;
        if (key_o !== key_v || din_o !== din_v) begin
            errors++;
            $display("FAIL load_key_din: got key=%h din=%h, expected key=%h din=%h", key_o, din_o, key_v, din_v);
        end
        cnt0 = start_cnt;
        wb_write(A_CTRL, 32'h3, 4'hf);
        checks++;
        if (start_o !== 1'b1) begin errors++; $display("FAIL start_pulse: got %b, expected 1", start_o); end
        repeat (9) @(negedge clk);
        done_i = 1'b1; dout_i = ct_v;
        @(negedge clk);
        done_i = 1'b0; dout_i = 128'h0;
        wait_idle(20);
        checks++;
        if (start_cnt - cnt0 !== 1) begin
            errors++;
            $display("FAIL start_count: got %0d pulses, expected 1", start_cnt - cnt0);
        end
        wb_read(A_STAT, d);
        checks++;
        if (d !== 32'h2) begin errors++; $display("FAIL enc_status: got %h, expected 2", d); end
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL enc_irq: got %b, expected 1", irq); end
        wb_read(A_DOUT, d);
        checks++;
        if (d !== 32'h70b4c55a) begin errors++; $display("FAIL dout0: got %h, expected 70b4c55a", d); end
        wb_read(A_DOUT + 32'hc, d);
        checks++;
        if (d !== 32'h69c4e0d8) begin errors++; $display("FAIL dout3: got %h, expected 69c4e0d8", d); end
    endtask

    task automatic test_timeout();
        logic [31:0] d;
        wb_write(A_CTRL, 32'h7, 4'hf);
        checks++;
        if (start_o !== 1'b1) begin errors++; $display("FAIL to_start: got %b, expected 1", start_o); end
        repeat (16) @(negedge clk);
        wb_read(A_STAT, d);
        checks++;
        if (d !== 32'h1) begin errors++; $display("FAIL to_status_c16: got %h, expected 1", d); end
        @(negedge clk);
        wb_read(A_STAT, d);
        checks++;
        if (d !== 32'h4) begin errors++; $display("FAIL to_status_c18: got %h, expected 4", d); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL to_irq: got %b, expected 0", irq); end
        wb_read(A_DOUT, d);
        checks++;
        if (d !== 32'h70b4c55a) begin errors++; $display("FAIL to_dout_kept: got %h, expected 70b4c55a", d); end
    endtask

    task automatic test_busy_write();
        logic [31:0] d;
        wb_write(A_CTRL, 32'h5, 4'hf);
        wb_write(A_KEY, 32'hdeadbeef, 4'hf);
        checks++;
        if (key_o[31:0] !== 32'h0c0d0e0f) begin
            errors++;
            $display("FAIL busy_key_stable: got %h, expected 0c0d0e0f", key_o[31:0]);
        end
        wb_read(A_STAT, d);
        checks++;
        if (d !== 32'h9) begin errors++; $display("FAIL busy_err: got %h, expected 9", d); end
        wb_write(A_CTRL, 32'h2, 4'hf);
        wb_read(A_CTRL, d);
        checks++;
        if (d !== 32'h2) begin errors++; $display("FAIL busy_irq_en: got %h, expected 2", d); end
        wait_idle(30);
        wb_read(A_STAT, d);
        checks++;
        if (d !== 32'hc) begin errors++; $display("FAIL busy_end_status: got %h, expected c", d); end
        wb_write(A_CTRL, 32'h4, 4'hf);
        wb_read(A_STAT, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL clr_status: got %h, expected 0", d); end
    endtask

    task automatic test_byte_sel();
        logic [31:0] d;
        wb_write(A_KEY + 32'h4, 32'h0, 4'hf);
        wb_write(A_KEY + 32'h4, 32'haabbccdd, 4'b0010);
        wb_read(A_KEY + 32'h4, d);
        checks++;
        if (d !== 32'h0000cc00) begin errors++; $display("FAIL byte_sel_read: got %h, expected 0000cc00", d); end
        checks++;
        if (key_o[63:32] !== 32'h0000cc00) begin
            errors++;
            $display("FAIL byte_sel_port: got %h, expected 0000cc00", key_o[63:32]);
        end
    endtask

    task automatic test_reset_midop();
        logic [31:0] d;
        int cnt0;
        wb_write(A_CTRL, 32'h1, 4'hf);
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        cnt0 = start_cnt;
        done_i = 1'b1; dout_i = ct_v;
        @(negedge clk);
        done_i = 1'b0; dout_i = 128'h0;
        repeat (3) @(negedge clk);
        checks++;
        if (start_cnt !== cnt0) begin
            errors++;
            $display("FAIL rst_no_start: got %0d pulses, expected 0", start_cnt - cnt0);
        end
        wb_read(A_STAT, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL rst_status: got %h, expected 0", d); end
        wb_read(A_DOUT, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL rst_dout0: got %h, expected 0", d); end
        wb_read(A_DOUT + 32'hc, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL rst_dout3: got %h, expected 0", d); end
        checks++;
        if (key_o !== 128'h0) begin errors++; $display("FAIL rst_key: got %h, expected 0", key_o); end
    endtask

    task automatic test_unmapped_hold();
        logic [31:0] d;
        logic [3:0]  pat;
        wb_read(32'h3000_0040, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL unmapped_read: got %h, expected 0", d); end
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0100;
        @(negedge clk);
        checks++;
        if (ack !== 1'b0) begin errors++; $display("FAIL out_of_window: got ack=%b, expected 0", ack); end
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; adr = 32'h3000_0040;
        pat[3] = ack;
        for (int i = 2; i >= 0; i--) begin
            @(negedge clk);
            pat[i] = ack;
        end
        cyc = 1'b0; stb = 1'b0;
        checks++;
        if (pat !== 4'b0101) begin errors++; $display("FAIL ack_pattern: got %b, expected 0101", pat); end
    endtask

    initial begin
        key_v = 128'h000102030405060708090a0b0c0d0e0f;
        din_v = 128'h00112233445566778899aabbccddeeff;
        ct_v  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        @(negedge clk);
        test_reset();
        test_encrypt();
        test_timeout();
        test_busy_write();
        test_byte_sel();
        test_reset_midop();
        test_unmapped_hold();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
